// File: rtl/pred_mode_encoder_if.sv
// Handshake and status bundle for pred_mode_encoder.
// slave is the encoder side; master is the producer/consumer side driving it.
interface pred_mode_encoder_if #(
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_pred_mode;
  logic             out_last;
  logic             err_clr;
  logic             err_illegal;
  logic [CNT_W-1:0] block_count;
  logic [CNT_W-1:0] intra_count;
  logic [CNT_W-1:0] inter_count;

  modport slave (
    input  in_valid, in_mode, in_last, out_ready, err_clr,
    output in_ready, out_valid, out_pred_mode, out_last, err_illegal,
           block_count, intra_count, inter_count
  );

  modport master (
    output in_valid, in_mode, in_last, out_ready, err_clr,
    input  in_ready, out_valid, out_pred_mode, out_last, err_illegal,
           block_count, intra_count, inter_count
  );
endinterface

// File: rtl/pred_mode_encoder.sv
// pred_mode_encoder: maps prediction decisions to the 8-bit pred_mode syntax code,
// buffers them in a small FIFO and emits them with frame delimiting.
// Optional feature macro: PRED_MODE_STATS_EN builds the intra/inter statistics
// counters; when undefined both count ports are tied to 0.
module pred_mode_encoder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input logic               clk,
  input logic               rst,
  pred_mode_encoder_if.slave bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  // Each entry is {code[7:0], last}.
  logic [8:0]       mem_q [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             err_q;
  logic [CNT_W-1:0] block_cnt_q;

  logic       full, empty;
  logic       push, pop;
  logic [7:0] in_code;
  logic [8:0] head;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // in_ready comes from registered pointers only, so a same-cycle pop never frees a slot.
  assign push = bus.in_valid && !full;
  assign pop  = !empty && bus.out_ready;

  // Illegal modes fall back to the Intra code.
  assign in_code = {7'b0, bus.in_mode == 2'd1};
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  assign bus.in_ready      = !full;
  assign bus.out_valid     = !empty;
  assign bus.out_pred_mode = empty ? 8'h00 : head[8:1];
  assign bus.out_last      = empty ? 1'b0 : head[0];
  assign bus.err_illegal   = err_q;
  assign bus.block_count   = block_cnt_q;

  // Entry storage; contents are don't-care while not between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {in_code, bus.in_last};
    end
  end

  // FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Sticky illegal-mode flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (push && bus.in_mode[1]) begin
      err_q <= 1'b1;
    end else if (bus.err_clr) begin
      err_q <= 1'b0;
    end
  end

  // Per-frame emitted-element counter, restarted by the frame's last element.
  always_ff @(posedge clk) begin
    if (rst) begin
      block_cnt_q <= '0;
    end else if (pop) begin
      if (head[0]) block_cnt_q <= '0;
      else         block_cnt_q <= block_cnt_q + CNT_W'(1);
    end
  end

`ifdef PRED_MODE_STATS_EN
  logic [CNT_W-1:0] intra_cnt_q, inter_cnt_q;

  // Accepted-decision statistics; illegal modes are counted as Intra.
  always_ff @(posedge clk) begin
    if (rst) begin
      intra_cnt_q <= '0;
      inter_cnt_q <= '0;
    end else if (push) begin
      if (bus.in_mode == 2'd1) inter_cnt_q <= inter_cnt_q + CNT_W'(1);
      else                     intra_cnt_q <= intra_cnt_q + CNT_W'(1);
    end
  end

  assign bus.intra_count = intra_cnt_q;
  assign bus.inter_count = inter_cnt_q;
`else
  assign bus.intra_count = '0;
  assign bus.inter_count = '0;
`endif

endmodule

// File: tb/tb_pred_mode_encoder.sv
// Directed self-checking bench for pred_mode_encoder (FIFO_DEPTH=4, CNT_W=16).
module tb_pred_mode_encoder;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pred_mode_encoder_if #(.CNT_W(16)) bus ();

  pred_mode_encoder #(
    .FIFO_DEPTH(4),
    .CNT_W     (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef PRED_MODE_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat(input int n);
    return StatsOn ? 32'(n) : 32'd0;
  endfunction

  task automatic drive(input logic v, input logic [1:0] m, input logic l);
    bus.in_valid = v;
    bus.in_mode  = m;
    bus.in_last  = l;
  endtask

  logic [1:0] fill_mode [5];
  logic       fill_last [5];

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(1'b0, 2'd0, 1'b0);
    bus.out_ready = 1'b0;
    bus.err_clr   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_code", bus.out_pred_mode, 8'h00);
    chk("rst_last", bus.out_last, 0);
    chk("rst_err", bus.err_illegal, 0);
    chk("rst_block", bus.block_count, 0);
    chk("rst_intra", bus.intra_count, 0);
    chk("rst_inter", bus.inter_count, 0);

    // Frame of three: Intra, Inter, Inter(last), streaming
    bus.out_ready = 1'b1;
    drive(1'b1, 2'd0, 1'b0);
    tick();
    chk("f1_valid0", bus.out_valid, 1);
    chk("f1_code0", bus.out_pred_mode, 8'h00);
    chk("f1_last0", bus.out_last, 0);
    drive(1'b1, 2'd1, 1'b0);
    tick();
    chk("f1_code1", bus.out_pred_mode, 8'h01);
    chk("f1_last1", bus.out_last, 0);
    chk("f1_block1", bus.block_count, 1);
    drive(1'b1, 2'd1, 1'b1);
    tick();
    chk("f1_code2", bus.out_pred_mode, 8'h01);
    chk("f1_last2", bus.out_last, 1);
    chk("f1_block2", bus.block_count, 2);
    drive(1'b0, 2'd0, 1'b0);
    tick();
    chk("f1_empty", bus.out_valid, 0);
    chk("f1_block0", bus.block_count, 0);
    chk("f1_intra", bus.intra_count, stat(1));
    chk("f1_inter", bus.inter_count, stat(2));

    // Fill with out_ready low; fifth decision must be refused
    fill_mode[0] = 2'd1; fill_last[0] = 1'b0;
    fill_mode[1] = 2'd0; fill_last[1] = 1'b0;
    fill_mode[2] = 2'd1; fill_last[2] = 1'b0;
    fill_mode[3] = 2'd0; fill_last[3] = 1'b1;
    fill_mode[4] = 2'd1; fill_last[4] = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, fill_mode[i], fill_last[i]);
      chk($sformatf("fill_ready%0d", i), bus.in_ready, 1);
      tick();
    end
    drive(1'b1, fill_mode[4], fill_last[4]);
    tick();
    chk("full_ready", bus.in_ready, 0);
    chk("full_head", bus.out_pred_mode, 8'h01);
    chk("full_valid", bus.out_valid, 1);

    // Pop while full with push pending: only the pop happens
    bus.out_ready = 1'b1;
    tick();
    chk("pp_ready", bus.in_ready, 1);
    chk("pp_head1", bus.out_pred_mode, 8'h00);
    chk("pp_block", bus.block_count, 1);
    tick();  // pops entry 1, accepts entry 4
    drive(1'b0, 2'd0, 1'b0);
    chk("drain_head2", bus.out_pred_mode, 8'h01);
    chk("drain_last2", bus.out_last, 0);
    tick();
    chk("drain_head3", bus.out_pred_mode, 8'h00);
    chk("drain_last3", bus.out_last, 1);
    chk("drain_block3", bus.block_count, 3);
    tick();
    chk("drain_head4", bus.out_pred_mode, 8'h01);
    chk("drain_last4", bus.out_last, 0);
    chk("drain_block_frame", bus.block_count, 0);
    tick();
    chk("drain_empty", bus.out_valid, 0);
    chk("drain_block", bus.block_count, 1);
    chk("drain_intra", bus.intra_count, stat(3));
    chk("drain_inter", bus.inter_count, stat(5));

    // Illegal mode handling
    drive(1'b1, 2'd3, 1'b0);
    tick();
    chk("ill_code", bus.out_pred_mode, 8'h00);
    chk("ill_valid", bus.out_valid, 1);
    chk("ill_err", bus.err_illegal, 1);
    drive(1'b1, 2'd2, 1'b0);
    bus.err_clr = 1'b1;
    tick();
    chk("ill_set_wins", bus.err_illegal, 1);
    drive(1'b0, 2'd0, 1'b0);
    tick();
    chk("ill_cleared", bus.err_illegal, 0);
    bus.err_clr = 1'b0;
    chk("ill_block", bus.block_count, 3);
    chk("ill_intra", bus.intra_count, stat(5));
    chk("ill_inter", bus.inter_count, stat(5));

    // Reset with three entries queued
    bus.out_ready = 1'b0;
    drive(1'b1, 2'd1, 1'b0);
    tick();
    tick();
    tick();
    drive(1'b0, 2'd0, 1'b0);
    chk("q3_valid", bus.out_valid, 1);
    chk("q3_ready", bus.in_ready, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_valid", bus.out_valid, 0);
    chk("mr_ready", bus.in_ready, 1);
    chk("mr_code", bus.out_pred_mode, 8'h00);
    chk("mr_block", bus.block_count, 0);
    chk("mr_intra", bus.intra_count, 0);
    chk("mr_inter", bus.inter_count, 0);
    chk("mr_err", bus.err_illegal, 0);

    // Statistics: 2 Intra, 3 Inter, 1 illegal
    bus.out_ready = 1'b1;
    drive(1'b1, 2'd0, 1'b0); tick();
    drive(1'b1, 2'd1, 1'b0); tick();
    drive(1'b1, 2'd0, 1'b0); tick();
    drive(1'b1, 2'd1, 1'b0); tick();
    drive(1'b1, 2'd2, 1'b0); tick();
    drive(1'b1, 2'd1, 1'b1); tick();
    drive(1'b0, 2'd0, 1'b0);
    chk("st_head_last", bus.out_last, 1);
    chk("st_block", bus.block_count, 5);
    tick();
    chk("st_empty", bus.out_valid, 0);
    chk("st_block0", bus.block_count, 0);
    chk("st_intra", bus.intra_count, stat(3));
    chk("st_inter", bus.inter_count, stat(3));
    chk("st_err", bus.err_illegal, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
